// File: rtl/fetch_queue_if.sv
// Bundle of the fetch queue's memory read bus and its pipeline-facing signals.
// The master modport is the fetch queue; the slave modport is memory plus stage 1.
interface fetch_queue_if;
    logic [15:0] mem_addr;
    logic        mem_req;
    logic        mem_ready;
    logic [7:0]  mem_data;
    logic [7:0]  instr;
    logic        instr_valid;
    logic [7:0]  const_data;
    logic        const_valid;
    logic        dispatch;
    logic        with_const;
    logic        jump;
    logic [15:0] jump_addr;
    logic        halt;
    logic [15:0] head_pc;
    logic        underflow;

    modport master (
        output mem_addr, mem_req, instr, instr_valid, const_data, const_valid,
               head_pc, underflow,
        input  mem_ready, mem_data, dispatch, with_const, jump, jump_addr, halt
    );

    modport slave (
        input  mem_addr, mem_req, instr, instr_valid, const_data, const_valid,
               head_pc, underflow,
        output mem_ready, mem_data, dispatch, with_const, jump, jump_addr, halt
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch unit: reads bytes from memory into a small FIFO and
// presents the head byte and the following constant byte to pipeline stage 1.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input logic           clk,
    input logic           rst,
    fetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQUEST, REDIRECT} state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   head_ptr;
    logic [PW-1:0]   tail_ptr;
    logic [PW-1:0]   const_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic [15:0]     fetch_addr;
    logic [15:0]     head_pc;
    logic            underflow;
    logic            push;
    logic [1:0]      pop_n;
    logic            short_dispatch;

    // A jump cancels both the returning byte and any dispatch in the same cycle.
    always_comb begin
        push           = (state == REQUEST) && bus.mem_ready && !bus.jump;
        pop_n          = 2'd0;
        short_dispatch = 1'b0;
        if (bus.dispatch && !bus.jump) begin
            if (bus.with_const) begin
                if (count >= CW'(2)) pop_n = 2'd2;
                else                 short_dispatch = 1'b1;
            end else begin
                if (count != '0) pop_n = 2'd1;
                else             short_dispatch = 1'b1;
            end
        end
        count_next = count + CW'(push) - CW'(pop_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            head_ptr   <= '0;
            tail_ptr   <= '0;
            count      <= '0;
            fetch_addr <= RESET_PC;
            head_pc    <= RESET_PC;
            underflow  <= 1'b0;
        end else if (bus.jump) begin
            state      <= REDIRECT;
            head_ptr   <= '0;
            tail_ptr   <= '0;
            count      <= '0;
            fetch_addr <= bus.jump_addr;
            head_pc    <= bus.jump_addr;
        end else begin
            if (push) begin
                tail_ptr   <= tail_ptr + 1'b1;
                fetch_addr <= fetch_addr + 16'd1;
            end
            head_ptr <= head_ptr + PW'(pop_n);
            head_pc  <= head_pc + 16'(pop_n);
            count    <= count_next;
            if (short_dispatch) underflow <= 1'b1;

            // The request stays up until the byte arrives, then continues only if room remains.
            case (state)
                REQUEST: begin
                    if (bus.mem_ready)
                        state <= (count_next < CW'(DEPTH) && !bus.halt) ? REQUEST : IDLE;
                end
                IDLE, REDIRECT: begin
                    state <= (count < CW'(DEPTH) && !bus.halt) ? REQUEST : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage carries no reset; stale entries are never visible because count gates the outputs.
    always_ff @(posedge clk) begin
        if (push) mem[tail_ptr] <= bus.mem_data;
    end

    assign const_ptr       = head_ptr + 1'b1;
    assign bus.mem_req     = (state == REQUEST);
    assign bus.mem_addr    = fetch_addr;
    assign bus.instr       = (count != '0) ? mem[head_ptr] : 8'h00;
    assign bus.instr_valid = (count != '0);
    assign bus.const_data  = (count >= CW'(2)) ? mem[const_ptr] : 8'h00;
    assign bus.const_valid = (count >= CW'(2));
    assign bus.head_pc     = head_pc;
    assign bus.underflow   = underflow;
endmodule
